// File: rtl/inst_mem_loader_pkg.sv
// Shared CPU definitions: fetch geometry, loader state encoding, instruction word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int AW    = 4;
  localparam int OPW   = 4;
  localparam int IMMW  = 4;
  localparam int DW    = OPW + IMMW;
  localparam int DEPTH = 2 ** AW;

  // Loader phases: waiting for a command, filling the RAM, CPU running.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ld_state_t;

  // Instruction word as seen by the CPU decoder: opcode in the upper nibble.
  typedef struct packed {
    logic [OPW-1:0]  opecode;
    logic [IMMW-1:0] imm;
  } inst_t;

endpackage

// File: rtl/inst_mem_loader_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port, async clear.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none, a write is taken whenever we is high.
module inst_ram #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next memory image: unchanged except the addressed word on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage; reset clears every word so a fresh CPU fetches harmless zeros.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-latency fetch for the single-cycle CPU.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_mem_loader.sv
// Program RAM responder for the CPU fetch port, filled at run time over a byte-wide load port.
// Latency: fetch is combinational in RUN; a load word is written on the edge it is accepted.
// Backpressure: load_ready is high for the whole LOAD phase, so words are accepted every valid cycle.
module inst_mem_loader #(
  parameter int AW   = cpu_pkg::AW,
  parameter int OPW  = cpu_pkg::OPW,
  parameter int IMMW = cpu_pkg::IMMW
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [AW-1:0]       addr,
  output logic [OPW-1:0]      opecode,
  output logic [IMMW-1:0]     imm,
  input  logic                load_start,
  input  logic                run_req,
  input  logic                load_valid,
  input  logic [OPW+IMMW-1:0] load_data,
  output logic                load_ready,
  output logic                load_done,
  output logic                cpu_n_rst,
  output logic [AW-1:0]       wptr
);

  import cpu_pkg::*;

  localparam int WW = OPW + IMMW;

  ld_state_t     state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          load_done_q, load_done_d;
  logic          cpu_n_rst_q, cpu_n_rst_d;
  logic          ram_we;
  logic [WW-1:0] ram_rdata;

  // Next-state, write pointer and write strobe. Commands are only honoured
  // in IDLE and RUN; a load always runs to 16 words once started.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    load_done_d = 1'b0;
    ram_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
        end else if (run_req) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (&wptr_q) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wptr_d  = '0;
      end
    endcase
    // CPU reset tracks the state being entered so it moves on the same edge.
    cpu_n_rst_d = (state_d == RUN);
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      load_done_q <= 1'b0;
      cpu_n_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      load_done_q <= load_done_d;
      cpu_n_rst_q <= cpu_n_rst_d;
    end
  end

  inst_ram #(
    .AW (AW),
    .DW (WW)
  ) u_ram (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (ram_we),
    .waddr (wptr_q),
    .wdata (load_data),
    .raddr (addr),
    .rdata (ram_rdata)
  );

  // Fetch is masked outside RUN so a half-loaded RAM is never visible.
  always_comb begin
    opecode = '0;
    imm     = '0;
    if (state_q == RUN) begin
      opecode = ram_rdata[WW-1 -: OPW];
      imm     = ram_rdata[IMMW-1:0];
    end
  end

  assign load_ready = (state_q == LOAD);
  assign load_done  = load_done_q;
  assign cpu_n_rst  = cpu_n_rst_q;
  assign wptr       = wptr_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] addr = '0;
  logic [3:0] opecode, imm;
  logic       load_start = 1'b0;
  logic       run_req = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready, load_done, cpu_n_rst;
  logic [3:0] wptr;

  always #5 clk = ~clk;

  inst_mem_loader dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .addr       (addr),
    .opecode    (opecode),
    .imm        (imm),
    .load_start (load_start),
    .run_req    (run_req),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .cpu_n_rst  (cpu_n_rst),
    .wptr       (wptr)
  );

  // Expected view of the outputs just after a rising edge.
  typedef struct packed {
    logic       cpu_n_rst;
    logic       rdy;
    logic       done;
    logic [3:0] wptr;
    logic [3:0] op;
    logic [3:0] imm;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_expected = 0;

  // Reference model: phase name, number of words written this load, program image.
  string m_phase = "idle";
  int    m_words = 0;
  inst_t m_prog [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = "idle";
    m_words = 0;
    for (int i = 0; i < 16; i++) m_prog[i] = '0;
  endtask

  // Drive one cycle of inputs and push what the outputs must look like after the edge.
  task automatic step(input logic ls, input logic rr, input logic lv,
                      input logic [7:0] ld, input logic [3:0] a);
    exp_t e;
    logic done;
    @(negedge clk);
    load_start = ls;
    run_req    = rr;
    load_valid = lv;
    load_data  = ld;
    addr       = a;
    done = 1'b0;
    if (m_phase == "idle") begin
      if (ls) begin
        m_phase = "load";
        m_words = 0;
      end else if (rr) begin
        m_phase = "run";
      end
    end else if (m_phase == "load") begin
      if (lv) begin
        m_prog[m_words] = inst_t'(ld);
        m_words++;
        if (m_words == 16) begin
          m_words = 0;
          m_phase = "run";
          done = 1'b1;
          done_expected++;
        end
      end
    end else begin
      if (ls) begin
        m_phase = "load";
        m_words = 0;
      end
    end
    e.cpu_n_rst = (m_phase == "run");
    e.rdy       = (m_phase == "load");
    e.done      = done;
    e.wptr      = 4'(m_words);
    e.op        = (m_phase == "run") ? m_prog[a].opecode : 4'h0;
    e.imm       = (m_phase == "run") ? m_prog[a].imm : 4'h0;
    sb.push_back(e);
  endtask

  task automatic idle_read(input logic [3:0] a);
    step(1'b0, 1'b0, 1'b0, 8'h00, a);
  endtask

  // Monitor: after every rising edge, compare the outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (load_done === 1'b1) done_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cpu_n_rst", 32'(cpu_n_rst), 32'(e.cpu_n_rst));
        chk("load_ready", 32'(load_ready), 32'(e.rdy));
        chk("load_done", 32'(load_done), 32'(e.done));
        chk("wptr", 32'(wptr), 32'(e.wptr));
        chk("opecode", 32'(opecode), 32'(e.op));
        chk("imm", 32'(imm), 32'(e.imm));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] prog2 [16];
    int         accepted;
    logic       v;

    model_reset();

    // 1. Reset, then idle with a nonzero fetch address.
    addr = 4'd5;
    #10;
    chk("rst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_fetch", 32'({opecode, imm}), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) idle_read(4'd5);

    // 2 + 4a. load_start with run_req together from IDLE, then a back-to-back load.
    prog2[0] = 8'h30;
    prog2[1] = 8'h71;
    for (int i = 2; i < 15; i++) prog2[i] = 8'(i - 1);
    prog2[15] = 8'hE7;
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, prog2[i], 4'(i));
    idle_read(4'd0);
    idle_read(4'd1);
    idle_read(4'd15);
    for (int i = 0; i < 6; i++) idle_read(4'($urandom_range(0, 15)));
    // run_req is ignored in RUN.
    step(1'b0, 1'b1, 1'b1, 8'hFF, 4'd2);

    // 3. Stalled load with alternating valid; slot 0 carries 0x3A.
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    accepted = 0;
    v = 1'b1;
    while (accepted < 16) begin
      step(1'b0, 1'b0, v, (accepted == 0) ? 8'h3A : 8'($urandom), 4'd0);
      if (v) accepted++;
      v = ~v;
    end
    idle_read(4'd0);
    idle_read(4'd3);

    // 4b + 5. Reload from RUN; commands during LOAD after 4 words have no effect.
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd9);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'hF3, 4'd9);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd9);
    step(1'b1, 1'b1, 1'b1, 8'hF3, 4'd9);
    step(1'b0, 1'b1, 1'b1, 8'hF3, 4'd9);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'hF3, 4'd9);
    idle_read(4'd9);
    idle_read(4'd0);

    // 6. Asynchronous reset between edges after 7 words of a new load.
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd2);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom), 4'd2);
    @(negedge clk);
    load_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("arst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    chk("arst_wptr", 32'(wptr), 32'd0);
    chk("arst_load_ready", 32'(load_ready), 32'd0);
    chk("arst_fetch", 32'({opecode, imm}), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'd2);
    idle_read(4'd2);
    idle_read(4'd7);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom_range(0, 15)));
    end

    idle_read(4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("load_done_pulses", 32'(done_seen), 32'(done_expected));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
